// File: rtl/data_path.sv
// -----------------------------------------------------------------------------
// data_path
//
// Single-bus processor datapath. An external control unit steers one source
// onto the shared bus through the *out strobes. It loads destinations through
// the *in strobes, which act on the rising clock edge. The ALU takes Y as
// operand A and the bus as operand B. It produces a double-width result that
// the two halves of Z capture independently.
//
// Ports
//   clock                      rising-edge clock
//   clear                      asynchronous active-low reset, clears every register
//   PCout, Zhighout, Zlowout,
//   MDRout, HIout, LOout,
//   R0out..R15out              bus source selects (fixed priority when several)
//   MARin, PCin, MDRin, IRin,
//   Yin, HIin, LOin,
//   R0in..R15in                load enables from the bus
//   ZHighIn, ZLowIn            load Z[2W-1:W] / Z[W-1:0] from the ALU result
//   IncPC                      PC <= PC + 1 (wins over PCin)
//   Read                       MDR source is Mdatain instead of the bus
//   Cin                        ALU carry/borrow in for add/sub
//   opcode                     ALU operation
//   Mdatain                    memory read data
//   BusMuxOut                  current bus value
//   IR_out, MAR_out, PC_val    register values for observation
// -----------------------------------------------------------------------------
module data_path #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    // bus source selects
    input  logic             PCout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    // load enables
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             R0in,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             ZHighIn,
    input  logic             ZLowIn,
    // control and data
    input  logic             IncPC,
    input  logic             Read,
    input  logic             Cin,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] Mdatain,
    // observability
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-1:0] MAR_out,
    output logic [WIDTH-1:0] PC_val
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_MUL  = 5'b10000,
        OP_DIV  = 5'b10001,
        OP_NEG  = 5'b10010,
        OP_NOT  = 5'b10011
    } alu_op_e;

    // Gather the per-register strobes into vectors, bit i = register i.
    logic [15:0] r_out_sel;
    logic [15:0] r_in_sel;

    assign r_out_sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                        R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign r_in_sel  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                        R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    // Architectural state
    logic [WIDTH-1:0] regs [16];
    logic [WIDTH-1:0] pc, ir, mar, mdr, hi, lo, y, z_hi, z_lo;

    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_c;

    // -------------------------------------------------------------------------
    // Bus multiplexer. Sources are applied from lowest to highest priority, so
    // the last match wins: R15..R0 (R0 ends up strongest among the registers),
    // then LO, HI, Zlow, Zhigh, PC and finally MDR.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assign every always_comb output a default before any branch;
        // a path that leaves it unassigned infers a latch.
        bus = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_out_sel[i]) bus = regs[i];
        end
        if (LOout)    bus = lo;
        if (HIout)    bus = hi;
        if (Zlowout)  bus = z_lo;
        if (Zhighout) bus = z_hi;
        if (PCout)    bus = pc;
        if (MDRout)   bus = mdr;
    end

    assign BusMuxOut = bus;

    // -------------------------------------------------------------------------
    // ALU: A = Y, B = bus.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]   alu_a, alu_b;
    logic [SW-1:0]      sh;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign alu_a = y;
    assign alu_b = bus;
    assign sh    = alu_b[SW-1:0];

    // The extra top bit carries out of add, or borrows out of sub.
    assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, Cin};
    assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH{1'b0}}, Cin};

    // A double-width product of sign-extended operands equals the signed product.
    assign prod = {{WIDTH{alu_a[WIDTH-1]}}, alu_a} * {{WIDTH{alu_b[WIDTH-1]}}, alu_b};

    // Signed divide. Division by zero and the single overflowing case are
    // steered away from the divider so the result is always defined.
    always_comb begin
        quo = '1;
        rem = alu_a;
        if (alu_b == '0) begin
            quo = '1;
            rem = alu_a;
        end else if (alu_a == MIN_INT && alu_b == '1) begin
            quo = MIN_INT;
            rem = '0;
        end else begin
            quo = $signed(alu_a) / $signed(alu_b);
            rem = $signed(alu_a) % $signed(alu_b);
        end
    end

    always_comb begin
        alu_c = '0;
        case (opcode)
            OP_ADD:  alu_c = {{(WIDTH-1){1'b0}}, sum_ext};
            OP_SUB:  alu_c = {{(WIDTH-1){1'b0}}, diff_ext};
            OP_AND:  alu_c = {{WIDTH{1'b0}}, alu_a & alu_b};
            OP_OR:   alu_c = {{WIDTH{1'b0}}, alu_a | alu_b};
            OP_ROR:  alu_c = {{WIDTH{1'b0}}, (alu_a >> sh) | (alu_a << (WIDTH - sh))};
            OP_ROL:  alu_c = {{WIDTH{1'b0}}, (alu_a << sh) | (alu_a >> (WIDTH - sh))};
            OP_SHR:  alu_c = {{WIDTH{1'b0}}, alu_a >> sh};
            OP_SHRA: alu_c = {{WIDTH{1'b0}}, $signed(alu_a) >>> sh};
            OP_SHL:  alu_c = {{WIDTH{1'b0}}, alu_a << sh};
            OP_MUL:  alu_c = prod;
            OP_DIV:  alu_c = {rem, quo};
            OP_NEG:  alu_c = {{WIDTH{1'b0}}, '0 - alu_b};
            OP_NOT:  alu_c = {{WIDTH{1'b0}}, ~alu_b};
            default: alu_c = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            // NOTE: the register file is cleared like any other state, so it
            // cannot map onto a RAM macro; here that is intended, as every
            // register must read 0 straight out of reset.
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            pc   <= '0;
            ir   <= '0;
            mar  <= '0;
            mdr  <= '0;
            hi   <= '0;
            lo   <= '0;
            y    <= '0;
            z_hi <= '0;
            z_lo <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every load samples the
            // bus value from before the edge, whatever the statement order.
            for (int i = 0; i < 16; i++) begin
                if (r_in_sel[i]) regs[i] <= bus;
            end
            if (MARin) mar <= bus;
            if (IRin)  ir  <= bus;
            if (Yin)   y   <= bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (MDRin) mdr <= Read ? Mdatain : bus;

            if (IncPC)     pc <= pc + ONE;
            else if (PCin) pc <= bus;

            if (ZLowIn)  z_lo <= alu_c[WIDTH-1:0];
            if (ZHighIn) z_hi <= alu_c[2*WIDTH-1:WIDTH];
        end
    end

    assign IR_out  = ir;
    assign MAR_out = mar;
    assign PC_val  = pc;

endmodule

// File: tb/tb_data_path.sv
// -----------------------------------------------------------------------------
// tb_data_path
//
// Drives register-transfer sequences into data_path. Expected observations are
// queued as each transfer is issued. A monitor on the falling clock edge pops
// every queued item and compares it with the DUT. Directed sequences carry
// literal expectations. Random ALU sequences use a behavioural reference model
// that tracks the programmer-visible registers.
// -----------------------------------------------------------------------------
module tb_data_path;

    logic        clock;
    logic        clear;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        ZHighIn, ZLowIn, IncPC, Read, Cin;
    logic [15:0] r_out, r_in;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, IR_out, MAR_out, PC_val;

    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110,
                           ROR = 5'b00111, ROL = 5'b01000, SHR = 5'b01001, SHRA = 5'b01010,
                           SHL = 5'b01011, MUL = 5'b10000, DIV = 5'b10001, NEG = 5'b10010,
                           NOT_ = 5'b10011;

    data_path #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin),
        .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
        .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
        .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .Cin(Cin),
        .opcode(opcode), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .IR_out(IR_out), .MAR_out(MAR_out), .PC_val(PC_val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------- scoreboard
    typedef enum {K_BUS, K_PC, K_MAR, K_IR} kind_e;
    typedef struct {
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always @(negedge clock) begin
        item_t       it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_PC:    act = PC_val;
                K_MAR:   act = MAR_out;
                K_IR:    act = IR_out;
                default: act = BusMuxOut;
            endcase
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------------- reference model
    logic [31:0] m_r [16];
    logic [31:0] m_mdr, m_pc, m_y, m_zlo, m_zhi, m_hi, m_lo;

    function automatic logic [63:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b, bit cin);
        int          ia = a;
        int          ib = b;
        longint      la = ia;
        longint      lb = ib;
        longint      q, r;
        longint      ua = {32'b0, a};
        longint      ub = {32'b0, b};
        logic [31:0] t  = a;
        int          s  = b[4:0];
        logic [63:0] c  = '0;
        case (op)
            ADD:  c = 64'(ua + ub + cin);
            SUB:  begin c[31:0] = a - b - cin; c[32] = (ua < ub + cin); end
            AND_: c[31:0] = a & b;
            OR_:  c[31:0] = a | b;
            ROR:  begin repeat (s) t = {t[0], t[31:1]}; c[31:0] = t; end
            ROL:  begin repeat (s) t = {t[30:0], t[31]}; c[31:0] = t; end
            SHR:  c[31:0] = a >> s;
            SHRA: c[31:0] = ia >>> s;
            SHL:  c[31:0] = a << s;
            MUL:  c = la * lb;
            DIV:  begin
                if (b == 0) c = {a, 32'hFFFF_FFFF};
                else begin
                    q = la / lb;
                    r = la % lb;
                    c = {r[31:0], q[31:0]};
                end
            end
            NEG:  c[31:0] = 32'd0 - b;
            NOT_: c[31:0] = ~b;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_mdr = '0; m_pc = '0; m_y = '0; m_zlo = '0; m_zhi = '0; m_hi = '0; m_lo = '0;
    endtask

    // ------------------------------------------------------------ drive helpers
    task automatic clr_strobes();
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin} = '0;
        {ZHighIn, ZLowIn, IncPC, Read, Cin} = '0;
        r_out = '0; r_in = '0; opcode = '0;
    endtask

    // Inputs are driven 1 time unit after a rising edge; this ends the cycle.
    task automatic cycle();
        @(posedge clock);
        #1;
        clr_strobes();
    endtask

    task automatic expect_val(kind_e k, string n, logic [31:0] e);
        item_t it;
        it.kind = k; it.name = n; it.exp = e;
        sb.push_back(it);
    endtask

    task automatic load_mem(logic [31:0] v, int dst, string n);
        Mdatain = v; Read = 1'b1; MDRin = 1'b1;
        cycle();
        m_mdr = v;
        MDRout = 1'b1; r_in[dst] = 1'b1;
        expect_val(K_BUS, n, v);
        cycle();
        m_r[dst] = v;
    endtask

    task automatic read_reg(int r, string n, logic [31:0] e);
        r_out[r] = 1'b1;
        expect_val(K_BUS, n, e);
        cycle();
    endtask

    task automatic to_y(int r);
        r_out[r] = 1'b1; Yin = 1'b1;
        cycle();
        m_y = m_r[r];
    endtask

    task automatic alu(logic [4:0] op, int rb, bit cin, bit lo, bit hi);
        logic [63:0] c;
        r_out[rb] = 1'b1; opcode = op; Cin = cin; ZLowIn = lo; ZHighIn = hi;
        c = ref_alu(op, m_y, m_r[rb], cin);
        cycle();
        if (lo) m_zlo = c[31:0];
        if (hi) m_zhi = c[63:32];
    endtask

    task automatic check_z(string n, logic [31:0] e_lo, logic [31:0] e_hi);
        Zlowout = 1'b1;
        expect_val(K_BUS, {n, "_zlo"}, e_lo);
        cycle();
        Zhighout = 1'b1;
        expect_val(K_BUS, {n, "_zhi"}, e_hi);
        cycle();
    endtask

    task automatic zlo_to_reg(int r);
        Zlowout = 1'b1; r_in[r] = 1'b1;
        cycle();
        m_r[r] = m_zlo;
    endtask

    task automatic reg_to_pc(int r);
        r_out[r] = 1'b1; PCin = 1'b1;
        cycle();
        m_pc = m_r[r];
    endtask

    // ------------------------------------------------------------------ stimulus
    logic [4:0] ops [15] = '{ADD, SUB, AND_, OR_, ROR, ROL, SHR, SHRA, SHL,
                             MUL, DIV, NEG, NOT_, 5'b00000, 5'b11111};

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        int          ra, rb;
        bit          cin, lo, hi;

        clr_strobes();
        Mdatain = '0;
        clear   = 1'b0;
        model_reset();
        expect_val(K_BUS, "rst_bus", 32'h0);
        expect_val(K_PC,  "rst_pc",  32'h0);
        expect_val(K_MAR, "rst_mar", 32'h0);
        expect_val(K_IR,  "rst_ir",  32'h0);
        cycle();
        cycle();
        clear = 1'b1;
        cycle();

        // Asynchronous clear mid-cycle: R5, PC and Z hold non-zero values first.
        load_mem(32'hDEAD_BEEF, 5, "pre_r5");
        to_y(5);
        alu(ADD, 5, 1'b0, 1'b1, 1'b1);
        check_z("pre_add", 32'hBD5B_7DDE, 32'h1);
        reg_to_pc(5);
        expect_val(K_PC, "pre_pc", 32'hDEAD_BEEF);
        cycle();
        #1;
        clear = 1'b0;
        r_out[5] = 1'b1;
        expect_val(K_BUS, "async_r5", 32'h0);
        expect_val(K_PC,  "async_pc", 32'h0);
        cycle();
        model_reset();
        check_z("async_z", 32'h0, 32'h0);
        clear = 1'b1;
        cycle();

        // Load path and the worked divide example
        load_mem(32'h3,  6, "ld_r6");
        load_mem(32'h12, 2, "ld_r2");
        read_reg(6, "rd_r6", 32'h3);
        read_reg(2, "rd_r2", 32'h12);
        to_y(2);
        alu(DIV, 6, 1'b0, 1'b1, 1'b1);
        check_z("div18_3", 32'h6, 32'h0);
        zlo_to_reg(2);
        read_reg(2, "div_r2", 32'h6);

        // Signed divide, divide by zero, overflowing divide
        load_mem(32'hFFFF_FFF9, 1, "ld_m7");
        load_mem(32'h2, 3, "ld_2");
        to_y(1);
        alu(DIV, 3, 1'b0, 1'b1, 1'b1);
        check_z("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        load_mem(32'h5, 1, "ld_5");
        load_mem(32'h0, 3, "ld_0");
        to_y(1);
        alu(DIV, 3, 1'b0, 1'b1, 1'b1);
        check_z("div_5_0", 32'hFFFF_FFFF, 32'h5);
        load_mem(32'h8000_0000, 1, "ld_min");
        load_mem(32'hFFFF_FFFF, 3, "ld_m1");
        to_y(1);
        alu(DIV, 3, 1'b0, 1'b1, 1'b1);
        check_z("div_min_m1", 32'h8000_0000, 32'h0);

        // Multiply; ZLowIn alone must leave Zhigh untouched
        load_mem(32'h2, 4, "ld_2b");
        to_y(3);
        alu(MUL, 4, 1'b0, 1'b1, 1'b1);
        check_z("mul_m1_2", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        alu(ADD, 4, 1'b1, 1'b1, 1'b0);
        check_z("zlo_only", 32'h2, 32'hFFFF_FFFF);

        // Fetch: PC=7 -> MAR=7, PC=8; then IR load
        load_mem(32'h7, 4, "ld_pc7");
        reg_to_pc(4);
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        expect_val(K_BUS, "fetch_bus", 32'h7);
        cycle();
        expect_val(K_MAR, "fetch_mar", 32'h7);
        expect_val(K_PC,  "fetch_pc",  32'h8);
        load_mem(32'h7A1B_8000, 9, "ld_instr");
        MDRout = 1'b1; IRin = 1'b1;
        cycle();
        expect_val(K_IR, "ir_load", 32'h7A1B_8000);
        // IncPC beats PCin
        r_out[9] = 1'b1; PCin = 1'b1; IncPC = 1'b1;
        cycle();
        expect_val(K_PC, "inc_over_pcin", 32'h9);
        // PC wrap
        load_mem(32'hFFFF_FFFF, 4, "ld_pcmax");
        reg_to_pc(4);
        expect_val(K_PC, "pc_max", 32'hFFFF_FFFF);
        IncPC = 1'b1;
        cycle();
        expect_val(K_PC, "pc_wrap", 32'h0);
        cycle();

        // MDR loads from the bus when Read is low
        r_out[6] = 1'b1; MDRin = 1'b1;
        cycle();
        MDRout = 1'b1;
        expect_val(K_BUS, "mdr_from_bus", 32'h3);
        cycle();

        // Bus priority
        load_mem(32'h500, 10, "ld_pcv");
        reg_to_pc(10);
        load_mem(32'hA0, 0, "ld_r0");
        load_mem(32'hA3, 3, "ld_r3");
        load_mem(32'hA9, 9, "ld_r9");
        load_mem(32'hAF, 15, "ld_r15");
        load_mem(32'h1111_1111, 7, "ld_hi");
        r_out[7] = 1'b1; HIin = 1'b1;
        cycle();
        load_mem(32'h2222_2222, 8, "ld_lo");
        r_out[8] = 1'b1; LOin = 1'b1;
        cycle();
        expect_val(K_BUS, "bus_idle", 32'h0);
        cycle();
        MDRout = 1'b1; r_out[3] = 1'b1;  expect_val(K_BUS, "pri_mdr_r3", 32'h2222_2222); cycle();
        MDRout = 1'b1; PCout = 1'b1;     expect_val(K_BUS, "pri_mdr_pc", 32'h2222_2222); cycle();
        PCout = 1'b1; Zhighout = 1'b1;   expect_val(K_BUS, "pri_pc_zhi", 32'h500);       cycle();
        Zhighout = 1'b1; Zlowout = 1'b1; expect_val(K_BUS, "pri_zhi_zlo", 32'hFFFF_FFFF); cycle();
        Zlowout = 1'b1; HIout = 1'b1;    expect_val(K_BUS, "pri_zlo_hi", 32'h2);         cycle();
        HIout = 1'b1; LOout = 1'b1;      expect_val(K_BUS, "pri_hi_lo", 32'h1111_1111);  cycle();
        LOout = 1'b1; r_out[0] = 1'b1;   expect_val(K_BUS, "pri_lo_r0", 32'h2222_2222);  cycle();
        r_out[3] = 1'b1; r_out[9] = 1'b1; expect_val(K_BUS, "pri_r3_r9", 32'hA3);        cycle();
        r_out[0] = 1'b1; r_out[15] = 1'b1; expect_val(K_BUS, "pri_r0_r15", 32'hA0);      cycle();

        // Randomised ALU sequences against the reference model
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 14)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(0, 31);
                2:       b = (op == DIV) ? 32'h0 : $urandom;
                default: b = 32'h0 - $urandom_range(1, 8);
            endcase
            ra  = $urandom_range(0, 15);
            rb  = (ra + 1 + $urandom_range(0, 14)) % 16;
            cin = 1'($urandom_range(0, 1));
            lo  = 1'($urandom_range(0, 3) != 0);
            hi  = 1'($urandom_range(0, 3) != 0);
            load_mem(a, ra, $sformatf("rnd%0d_lda", i));
            load_mem(b, rb, $sformatf("rnd%0d_ldb", i));
            to_y(ra);
            alu(op, rb, cin, lo, hi);
            check_z($sformatf("rnd%0d_op%0d", i, op), m_zlo, m_zhi);
            if (i % 4 == 0) begin
                zlo_to_reg(ra);
                read_reg(ra, $sformatf("rnd%0d_wb", i), m_r[ra]);
            end
        end

        cycle();
        cycle();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
